// File: rtl/riscv_multi_pkg.sv
// rtl/riscv_multi_pkg.sv - shared opcodes, fault causes and memory-stage states for the multicycle core
package riscv_multi_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_BUSERR   = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } fault_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - counts BUSY cycles, flags expiry on the last allowed cycle
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClear,
  input  logic iEnable,
  output logic oExpired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign oExpired = (cnt_q == LAST);

  // Saturate at LAST so a held enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (iClear)
      cnt_d = '0;
    else if (iEnable && !oExpired)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_access_ctrl_multi.sv
// rtl/mem_access_ctrl_multi.sv - memory-access stage: held bus request, stall, IR/MDR latch, fault report
module mem_access_ctrl_multi
  import riscv_multi_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] IR_RESET = 32'h00000013
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic              iIRWrite,
  input  logic              iIorD,
  input  logic [ADDR_W-1:0] iPC,
  input  logic [ADDR_W-1:0] iALUOut,
  input  logic [DATA_W-1:0] iWriteData,
  output logic              oStall,
  output logic              oBusReq,
  output logic              oBusWe,
  output logic [ADDR_W-1:0] oBusAddr,
  output logic [DATA_W-1:0] oBusWData,
  input  logic              iBusAck,
  input  logic              iBusErr,
  input  logic [DATA_W-1:0] iBusRData,
  output logic [DATA_W-1:0] oIR,
  output logic [6:0]        oOpcode,
  output logic [DATA_W-1:0] oMDR,
  output logic              oFault,
  output logic [1:0]        oFaultCause
);

  mem_state_e        state_q;
  fault_cause_e      cause_q;
  logic              req_q, we_q, irsel_q, fault_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ir_q, mdr_q;
  logic              req, expired;
  logic [ADDR_W-1:0] addr;

  assign req  = iMemRead | iMemWrite;
  assign addr = iIorD ? iALUOut : iPC;

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iClear   (state_q != ST_BUSY),
    .iEnable  (state_q == ST_BUSY),
    .oExpired (expired)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      irsel_q <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= DATA_W'(IR_RESET);
      mdr_q   <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            // Illegal or misaligned requests complete without ever touching the bus.
            if (iMemRead && iMemWrite) begin
              state_q <= ST_DONE;
              cause_q <= CAUSE_BUSERR;
              fault_q <= 1'b1;
            end else if (addr[1:0] != 2'b00) begin
              state_q <= ST_DONE;
              cause_q <= CAUSE_MISALIGN;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_BUSY;
              cause_q <= CAUSE_NONE;
              req_q   <= 1'b1;
              we_q    <= iMemWrite;
              irsel_q <= iIRWrite;
              addr_q  <= addr;
              wdata_q <= iWriteData;
            end
          end
        end
        ST_BUSY: begin
          if (iBusAck || expired) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
          if (iBusAck) begin
            if (iBusErr) begin
              cause_q <= CAUSE_BUSERR;
              fault_q <= 1'b1;
            end else if (!we_q) begin
              if (irsel_q) ir_q  <= iBusRData;
              else         mdr_q <= iBusRData;
            end
          end else if (expired) begin
            cause_q <= CAUSE_TIMEOUT;
            fault_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oStall      = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && req);
  assign oBusReq     = req_q;
  assign oBusWe      = we_q;
  assign oBusAddr    = addr_q;
  assign oBusWData   = wdata_q;
  assign oIR         = ir_q;
  assign oOpcode     = ir_q[6:0];
  assign oMDR        = mdr_q;
  assign oFault      = fault_q;
  assign oFaultCause = cause_q;

endmodule

// File: tb/tb_mem_access_ctrl_multi.sv
// tb/tb_mem_access_ctrl_multi.sv - randomized and directed bench with a transaction-level reference model
module tb_mem_access_ctrl_multi;

  localparam int TO = 4;
  localparam logic [31:0] IR_RST = 32'h00000013;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iMemRead = 0, iMemWrite = 0, iIRWrite = 0, iIorD = 0;
  logic [31:0] iPC = 0, iALUOut = 0, iWriteData = 0;
  logic        oStall, oBusReq, oBusWe, oFault;
  logic [31:0] oBusAddr, oBusWData, oIR, oMDR;
  logic [6:0]  oOpcode;
  logic [1:0]  oFaultCause;
  logic        iBusAck = 0, iBusErr = 0;
  logic [31:0] iBusRData = 0;

  mem_access_ctrl_multi #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .IR_RESET(IR_RST)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iIRWrite(iIRWrite),
    .iIorD(iIorD), .iPC(iPC), .iALUOut(iALUOut), .iWriteData(iWriteData), .oStall(oStall),
    .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr), .oBusWData(oBusWData),
    .iBusAck(iBusAck), .iBusErr(iBusErr), .iBusRData(iBusRData), .oIR(oIR), .oOpcode(oOpcode),
    .oMDR(oMDR), .oFault(oFault), .oFaultCause(oFaultCause)
  );

  always #5 iCLK = ~iCLK;

  // Expected outputs for the current cycle, set by the stimulus process.
  bit          chk_en = 0;
  logic        exp_stall, exp_busreq, exp_we, exp_fault;
  logic [31:0] exp_addr, exp_wdata, exp_ir, exp_mdr;
  logic [1:0]  exp_cause;
  int          stall_cnt, req_cnt;

  int          pin_sel = 0;
  string       pin_name = "";
  logic [31:0] pin_exp = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pick(input int s);
    case (s)
      1:  return oIR;
      2:  return {25'd0, oOpcode};
      3:  return oMDR;
      4:  return oBusAddr;
      5:  return oBusWData;
      6:  return {30'd0, oFaultCause};
      7:  return 32'(stall_cnt);
      8:  return 32'(req_cnt);
      9:  return {31'd0, oBusReq};
      10: return {31'd0, oStall};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(negedge iCLK) begin
    if (chk_en) begin
      chk("stall",  {31'd0, oStall},      {31'd0, exp_stall});
      chk("busreq", {31'd0, oBusReq},     {31'd0, exp_busreq});
      chk("buswe",  {31'd0, oBusWe},      {31'd0, exp_we});
      chk("addr",   oBusAddr,             exp_addr);
      chk("wdata",  oBusWData,            exp_wdata);
      chk("ir",     oIR,                  exp_ir);
      chk("opcode", {25'd0, oOpcode},     {25'd0, exp_ir[6:0]});
      chk("mdr",    oMDR,                 exp_mdr);
      chk("fault",  {31'd0, oFault},      {31'd0, exp_fault});
      chk("cause",  {30'd0, oFaultCause}, {30'd0, exp_cause});
    end
    if (pin_sel != 0) chk(pin_name, pick(pin_sel), pin_exp);
  end

  task automatic step();
    @(negedge iCLK);
    if (oStall)  stall_cnt++;
    if (oBusReq) req_cnt++;
    @(posedge iCLK);
    #1;
  endtask

  task automatic pin(input string name, input int sel, input logic [31:0] e);
    pin_name = name;
    pin_sel  = sel;
    pin_exp  = e;
    @(negedge iCLK);
    #1;
    pin_sel = 0;
    @(posedge iCLK);
    #1;
  endtask

  // One whole access from the control's point of view: IDLE, n BUSY cycles, DONE, then idle gap.
  task automatic do_access(input bit rd, input bit wr, input bit irw, input bit iord,
                           input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                           input int waits, input bit err, input logic [31:0] rdata);
    logic [31:0] a;
    int          nb;
    bit          tmo;
    logic [1:0]  c;
    a = iord ? alu : pc;
    tmo = 0;
    stall_cnt = 0;
    req_cnt = 0;
    iMemRead = rd; iMemWrite = wr; iIRWrite = irw; iIorD = iord;
    iPC = pc; iALUOut = alu; iWriteData = wd;
    iBusAck = 1'($urandom_range(0, 1)); iBusErr = 1'($urandom_range(0, 1)); iBusRData = $urandom;
    exp_stall = 1; exp_busreq = 0; exp_we = 0; exp_fault = 0;
    step();
    if (rd && wr) begin
      c = 2'd2; nb = 0;
    end else if (a[1:0] != 2'b00) begin
      c = 2'd1; nb = 0;
    end else begin
      tmo = (waits >= TO);
      nb = tmo ? TO : waits + 1;
      c = tmo ? 2'd3 : (err ? 2'd2 : 2'd0);
      exp_addr = a; exp_wdata = wd; exp_cause = 2'd0;
    end
    for (int k = 1; k <= nb; k++) begin
      exp_stall = 1; exp_busreq = 1; exp_we = wr; exp_fault = 0;
      iBusAck   = (!tmo && k == nb);
      iBusErr   = iBusAck ? err : 1'($urandom_range(0, 1));
      iBusRData = iBusAck ? rdata : $urandom;
      step();
    end
    exp_stall = 0; exp_busreq = 0; exp_we = 0; exp_cause = c; exp_fault = (c != 2'd0);
    if (c == 2'd0 && rd) begin
      if (irw) exp_ir = rdata;
      else     exp_mdr = rdata;
    end
    iBusAck = 1'($urandom_range(0, 1)); iBusErr = 1'($urandom_range(0, 1)); iBusRData = $urandom;
    step();
    iMemRead = 0; iMemWrite = 0;
    exp_stall = 0; exp_fault = 0;
    repeat ($urandom_range(1, 2)) begin
      iBusAck = 1'($urandom_range(0, 1)); iBusRData = $urandom;
      step();
    end
    iBusAck = 0;
  endtask

  initial begin
    repeat (2) @(posedge iCLK);
    #1;
    pin("rst_ir", 1, IR_RST);
    pin("rst_busreq", 9, 0);
    pin("rst_cause", 6, 0);
    pin("rst_mdr", 3, 0);
    iRST = 0;
    exp_stall = 0; exp_busreq = 0; exp_we = 0; exp_fault = 0;
    exp_addr = 0; exp_wdata = 0; exp_ir = IR_RST; exp_mdr = 0; exp_cause = 0;
    chk_en = 1;
    step();

    do_access(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 0, 0, 32'h00A00093);
    pin("fetch_addr", 4, 32'h40);
    pin("fetch_ir", 1, 32'h00A00093);
    pin("fetch_opcode", 2, 32'b0010011);
    pin("fetch_stall_cycles", 7, 2);

    do_access(1, 0, 0, 1, 32'h44, 32'h1004, 32'h0, 3, 0, 32'hCAFEF00D);
    pin("load_mdr", 3, 32'hCAFEF00D);
    pin("load_ir_kept", 1, 32'h00A00093);
    pin("load_stall_cycles", 7, 5);

    do_access(0, 1, 0, 1, 32'h48, 32'h2000, 32'h12345678, 1, 0, 32'h0);
    pin("store_wdata", 5, 32'h12345678);
    pin("store_mdr_kept", 3, 32'hCAFEF00D);
    pin("store_cause", 6, 0);

    do_access(1, 0, 0, 1, 32'h4C, 32'h2002, 32'h0, 0, 0, 32'h0);
    pin("misalign_req_cycles", 8, 0);
    pin("misalign_stall_cycles", 7, 1);
    pin("misalign_cause", 6, 1);

    do_access(1, 0, 0, 1, 32'h50, 32'h3000, 32'h0, 20, 0, 32'h0);
    pin("timeout_req_cycles", 8, TO);
    pin("timeout_cause", 6, 3);

    do_access(1, 0, 0, 1, 32'h54, 32'h3004, 32'h0, 0, 1, 32'h5555AAAA);
    pin("buserr_cause", 6, 2);
    pin("buserr_mdr_kept", 3, 32'hCAFEF00D);

    do_access(1, 1, 0, 1, 32'h58, 32'h3008, 32'h0, 0, 0, 32'h0);
    pin("rdwr_req_cycles", 8, 0);
    pin("rdwr_cause", 6, 2);

    for (int i = 0; i < 150; i++) begin
      int          kind;
      bit          rd, wr;
      logic [31:0] alu, pc;
      kind = $urandom_range(0, 9);
      rd = (kind <= 5);
      wr = (kind == 0) || (kind >= 6);
      pc  = {$urandom, 2'b00} >> 2 << 2;
      alu = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
      do_access(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc, alu, $urandom,
                $urandom_range(0, 5), ($urandom_range(0, 5) == 0), $urandom);
    end

    do_access(1, 0, 0, 1, 32'h60, 32'h1010, 32'h0, 0, 0, 32'h77778888);
    chk_en = 0;
    iMemRead = 1; iIorD = 1; iALUOut = 32'h3000; iIRWrite = 0; iBusAck = 0;
    step();
    iRST = 1; iMemRead = 0; iBusAck = 1; iBusRData = 32'hDEADBEEF;
    pin("async_rst_busreq", 9, 0);
    pin("async_rst_addr", 4, 0);
    iRST = 0;
    pin("late_ack_ir", 1, IR_RST);
    iBusAck = 0;
    pin("late_ack_mdr", 3, 0);
    pin("late_ack_stall", 10, 0);
    pin("late_ack_busreq", 9, 0);
    pin("late_ack_cause", 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
